dendrite_update_scheduler: RTL and testbench
============================================

Name: dendrite_update_scheduler

Overview:
Time-multiplexes one shared saturating accumulate datapath across NUM_DEND dendrite compartments held in an internal membrane register file.
- Buffers incoming synaptic current events in a small FIFO and applies them one per cycle.
- On each timestep tick, runs a leak sweep over all compartments.
- Sits between the synapse event fabric and the neuron-side readout; replaces per-compartment adder pairs with a single scheduled adder.

Parameters:
NUM_DEND, 8, number of compartments (power of two, >=2)
WORD_LENGTH, 16, membrane/current width, signed two's complement
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
LEAK_SHIFT, 3, leak = vmem >>> LEAK_SHIFT per tick

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ev_valid  in  1  event offered
ev_ready  out  1  FIFO can accept (= !full)
ev_idx  in  $clog2(NUM_DEND)  target compartment
ev_current  in  WORD_LENGTH  signed current to add
tick  in  1  timestep strobe, single cycle
busy  out  1  FSM not IDLE or FIFO non-empty
upd_valid  out  1  one-cycle pulse: a compartment was written
upd_idx  out  $clog2(NUM_DEND)  compartment written
upd_vmem  out  WORD_LENGTH  value written
rd_idx  in  $clog2(NUM_DEND)  readout select
rd_vmem  out  WORD_LENGTH  combinational read of vmem[rd_idx]
tick_overrun  out  1  sticky: tick arrived while one already pending

Behaviour:
- Reset: all vmem=0, FIFO empty, FSM=IDLE, tick_pending=0, sweep counter=0, upd_valid=0, upd_idx=0, upd_vmem=0, tick_overrun=0, ev_ready=1 in the cycle after reset. Reset mid-sweep or with FIFO non-empty aborts the sweep and discards queued events.
- Accept: event enqueued on any edge with ev_valid && ev_ready. ev_ready = !full, independent of ev_valid. Enqueue and dequeue in the same cycle while full is not allowed, because ready is already low.
- Tick capture: tick sets tick_pending. If tick_pending is already 1 and the sweep has not started, set tick_overrun and drop the tick. A tick during LEAK sets tick_pending normally.
- FSM state IDLE:
  - If tick_pending: go to LEAK, clear tick_pending, counter=0. Tick has priority over events.
  - Else if FIFO non-empty: pop head, write vmem[idx] = sat(vmem[idx] + current).
- FSM state LEAK:
  - Each cycle: vmem[cnt] = vmem[cnt] - (vmem[cnt] >>> LEAK_SHIFT), then cnt++.
  - After cnt = NUM_DEND-1 is written, return to IDLE. The sweep takes exactly NUM_DEND cycles.
  - Events are only enqueued during LEAK, never popped.
- Latency:
  - Event accepted at edge E into an empty FIFO with FSM idle and no tick pending: vmem written at edge E+1; upd_valid/upd_idx/upd_vmem valid in the cycle after E+1.
  - Throughput: one event per cycle.
- upd_* reports every write, both event writes and leak writes. upd_valid is 0 otherwise.
- Saturation: the sum is computed at WORD_LENGTH+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. Leak never overflows. Leak of -1 with LEAK_SHIFT>=1 gives 0.
- rd_vmem shows the pre-write value in the cycle a write occurs; the new value is visible from the next cycle.
- ev_idx >= NUM_DEND cannot occur (power-of-two NUM_DEND).

Optional Feature:
DENDRITE_SCHED_LEAK_EN
- Defined: tick, LEAK state, tick_pending and tick_overrun behave as above.
- Undefined: LEAK state not built; tick ignored; tick_overrun tied 0; FIFO is popped every cycle it is non-empty; busy = FIFO non-empty.

Test Plan:
- Reset, then event idx=2 current=100 -> upd_valid one cycle later with idx=2, vmem=100; rd_idx=2 reads 100; other compartments read 0.
- vmem[5]=32760, event idx=5 current=+20 -> vmem[5]=32767. Then event current=-32768 -> -1.
- vmem[0]=80, vmem[1]=-80, tick -> exactly 8 upd pulses, idx 0..7; vmem[0]=70, vmem[1]=-70; others stay 0.
- During a sweep, offer 5 back-to-back events -> ev_ready drops after 4 accepted. After the sweep, the 4 events are applied on 4 consecutive cycles in FIFO order; the 5th is accepted once space frees.
- Tick, then tick again during the sweep, then a third tick before the second sweep starts -> two sweeps (16 leak writes), tick_overrun=1.
- Assert reset mid-sweep with 3 events queued -> next cycle: all vmem=0, busy=0, ev_ready=1; no upd_valid for the flushed events.

Source files
------------

// File: rtl/dendrite_update_scheduler.sv
// Dendrite membrane file updated by one shared saturating adder: queued synaptic events
// and, when DENDRITE_SCHED_LEAK_EN is defined, a per-tick leak sweep over every compartment.
module dendrite_update_scheduler #(
    parameter int NUM_DEND    = 8,
    parameter int WORD_LENGTH = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEAK_SHIFT  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [$clog2(NUM_DEND)-1:0] ev_idx,
    input  logic [WORD_LENGTH-1:0]      ev_current,
    input  logic                        tick,
    output logic                        busy,
    output logic                        upd_valid,
    output logic [$clog2(NUM_DEND)-1:0] upd_idx,
    output logic [WORD_LENGTH-1:0]      upd_vmem,
    input  logic [$clog2(NUM_DEND)-1:0] rd_idx,
    output logic [WORD_LENGTH-1:0]      rd_vmem,
    output logic                        tick_overrun
);

    localparam int IDX_W = $clog2(NUM_DEND);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic signed [WORD_LENGTH-1:0] VMEM_MAX = {1'b0, {(WORD_LENGTH - 1){1'b1}}};
    localparam logic signed [WORD_LENGTH-1:0] VMEM_MIN = {1'b1, {(WORD_LENGTH - 1){1'b0}}};

    logic signed [WORD_LENGTH-1:0] vmem [NUM_DEND];

    // Event FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDX_W-1:0]              fifo_idx     [FIFO_DEPTH];
    logic signed [WORD_LENGTH-1:0] fifo_current [FIFO_DEPTH];
    logic [PTR_W:0]                wr_ptr;
    logic [PTR_W:0]                rd_ptr;
    logic [PTR_W:0]                fifo_count;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          push;
    logic                          pop;
    logic [IDX_W-1:0]              head_idx;
    logic signed [WORD_LENGTH-1:0] head_current;

    assign fifo_count   = wr_ptr - rd_ptr;
    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == FIFO_FULL_COUNT);
    assign ev_ready     = !fifo_full;
    assign push         = ev_valid && !fifo_full;
    assign head_idx     = fifo_idx[rd_ptr[PTR_W-1:0]];
    assign head_current = fifo_current[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO payload is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr[PTR_W-1:0]]     <= ev_idx;
            fifo_current[wr_ptr[PTR_W-1:0]] <= $signed(ev_current);
        end
    end

    // Shared datapath: one W+1-bit adder, clamped back to the W-bit signed range.
    logic                          wr_en;
    logic [IDX_W-1:0]              wr_idx;
    logic signed [WORD_LENGTH-1:0] opnd_a;
    logic signed [WORD_LENGTH:0]   opnd_b;
    logic signed [WORD_LENGTH:0]   event_b;
    logic signed [WORD_LENGTH:0]   sum;
    logic signed [WORD_LENGTH-1:0] sat_sum;

    assign event_b = $signed({head_current[WORD_LENGTH-1], head_current});
    assign sum     = $signed({opnd_a[WORD_LENGTH-1], opnd_a}) + opnd_b;

    always_comb begin
        sat_sum = sum[WORD_LENGTH-1:0];
        if (sum[WORD_LENGTH] != sum[WORD_LENGTH-1]) begin
            sat_sum = sum[WORD_LENGTH] ? VMEM_MIN : VMEM_MAX;
        end
    end

`ifdef DENDRITE_SCHED_LEAK_EN
    typedef enum logic {
        S_IDLE,
        S_LEAK
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEND - 1);

    state_t                        state;
    state_t                        state_next;
    logic [IDX_W-1:0]              sweep_cnt;
    logic [IDX_W-1:0]              sweep_cnt_next;
    logic                          sweep_start;
    logic                          tick_pending;
    logic signed [WORD_LENGTH-1:0] leak_amt;

    assign leak_amt = vmem[sweep_cnt] >>> LEAK_SHIFT;
    assign busy     = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        sweep_start    = 1'b0;
        pop            = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = head_idx;
        opnd_a         = vmem[head_idx];
        opnd_b         = event_b;
        case (state)
            S_IDLE: begin
                if (tick_pending) begin
                    state_next     = S_LEAK;
                    sweep_cnt_next = '0;
                    sweep_start    = 1'b1;
                end else if (!fifo_empty) begin
                    pop   = 1'b1;
                    wr_en = 1'b1;
                end
            end
            S_LEAK: begin
                wr_en          = 1'b1;
                wr_idx         = sweep_cnt;
                opnd_a         = vmem[sweep_cnt];
                opnd_b         = -$signed({leak_amt[WORD_LENGTH-1], leak_amt});
                sweep_cnt_next = sweep_cnt + 1'b1;
                if (sweep_cnt == LAST_IDX) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A tick landing in the cycle the pending one is consumed re-arms instead of overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_pending <= 1'b0;
            tick_overrun <= 1'b0;
        end else if (tick) begin
            if (tick_pending && !sweep_start) tick_overrun <= 1'b1;
            else                              tick_pending <= 1'b1;
        end else if (sweep_start) begin
            tick_pending <= 1'b0;
        end
    end
`else
    logic unused_tick;

    assign unused_tick  = tick ^ (LEAK_SHIFT != 0);
    assign busy         = !fifo_empty;
    assign tick_overrun = 1'b0;

    always_comb begin
        pop    = !fifo_empty;
        wr_en  = !fifo_empty;
        wr_idx = head_idx;
        opnd_a = vmem[head_idx];
        opnd_b = event_b;
    end
`endif

    // NOTE: the membrane file is reset element by element because reset must zero every compartment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DEND; i++) vmem[i] <= '0;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_vmem  <= '0;
        end else begin
            upd_valid <= wr_en;
            if (wr_en) begin
                vmem[wr_idx] <= sat_sum;
                upd_idx      <= wr_idx;
                upd_vmem     <= sat_sum;
            end
        end
    end

    assign rd_vmem = vmem[rd_idx];

endmodule

// File: tb/tb_dendrite_update_scheduler.sv
// Directed bench for dendrite_update_scheduler: an in-order write scoreboard plus literal expectations.
// Leak-sweep scenarios are exercised when DENDRITE_SCHED_LEAK_EN is defined.
module tb_dendrite_update_scheduler;

    localparam int NUM_DEND   = 8;
    localparam int W          = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int VMAX       = 32767;
    localparam int VMIN       = -32768;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         ev_valid   = 1'b0;
    logic         ev_ready;
    logic [2:0]   ev_idx     = '0;
    logic [W-1:0] ev_current = '0;
    logic         tick       = 1'b0;
    logic         busy;
    logic         upd_valid;
    logic [2:0]   upd_idx;
    logic [W-1:0] upd_vmem;
    logic [2:0]   rd_idx     = '0;
    logic [W-1:0] rd_vmem;
    logic         tick_overrun;

    dendrite_update_scheduler #(
        .NUM_DEND(NUM_DEND),
        .WORD_LENGTH(W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_idx(ev_idx),
        .ev_current(ev_current),
        .tick(tick),
        .busy(busy),
        .upd_valid(upd_valid),
        .upd_idx(upd_idx),
        .upd_vmem(upd_vmem),
        .rd_idx(rd_idx),
        .rd_vmem(rd_vmem),
        .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_leak;
        int idx;
        int cur;
    } op_t;

    // Writes the design owes us, in the order they must appear on upd_*.
    op_t exp_q[$];
    int  model_vmem [NUM_DEND];
    int  checks    = 0;
    int  failures  = 0;
    int  upd_count = 0;
    int  cyc       = 0;
    op_t cmp_op;
    int  cmp_want;
    int  snap;
    int  c0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        int s = a + b;
        if (s > VMAX) return VMAX;
        if (s < VMIN) return VMIN;
        return s;
    endfunction

    // Leak removes floor(v / 2^LEAK_SHIFT) from the membrane.
    function automatic int leak_of(input int v);
        int d  = 1 << LEAK_SHIFT;
        int fl = (v >= 0) ? (v / d) : -((-v + d - 1) / d);
        return v - fl;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (upd_valid) begin
                upd_count++;
                check("upd_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cmp_op   = exp_q.pop_front();
                    cmp_want = cmp_op.is_leak ? leak_of(model_vmem[cmp_op.idx])
                                              : sat_add(model_vmem[cmp_op.idx], cmp_op.cur);
                    check("upd_idx", int'(upd_idx), cmp_op.idx);
                    check("upd_vmem", int'($signed(upd_vmem)), cmp_want);
                    model_vmem[cmp_op.idx] = cmp_want;
                end
            end
            check("rd_vmem", int'($signed(rd_vmem)), model_vmem[rd_idx]);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_DEND; i++) model_vmem[i] = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Offers one event and holds it until accepted; ev_ready is registered-derived so the
    // negedge value is the value at the following edge.
    task automatic send(input int idx, input int cur);
        bit acc = 1'b0;
        int waited = 0;
        ev_valid   = 1'b1;
        ev_idx     = 3'(idx);
        ev_current = W'(cur);
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = ev_ready;
            @(posedge clk); #1;
            waited++;
        end
        ev_valid = 1'b0;
        check("send_accept", int'(acc), 1);
        if (acc) exp_q.push_back('{is_leak: 1'b0, idx: idx, cur: cur});
    endtask

    task automatic pulse_tick(input bit sweeps);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        if (sweeps) for (int i = 0; i < NUM_DEND; i++) exp_q.push_back('{is_leak: 1'b1, idx: i, cur: 0});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", int'(n < 300), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_expect(input int idx, input int val, input string name);
        rd_idx = 3'(idx);
        @(posedge clk); #1;
        check(name, int'($signed(rd_vmem)), val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_idx", int'(upd_idx), 0);
        check("rst_upd_vmem", int'(upd_vmem), 0);
        check("rst_ev_ready", ev_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_overrun", tick_overrun, 0);
        check("rst_rd", int'($signed(rd_vmem)), 0);

        // Latency: write one edge after acceptance, upd_* visible the cycle after that.
        rd_idx     = 3'd2;
        ev_valid   = 1'b1;
        ev_idx     = 3'd2;
        ev_current = 16'd100;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        exp_q.push_back('{is_leak: 1'b0, idx: 2, cur: 100});
        @(negedge clk);
        check("lat_upd_early", upd_valid, 0);
        check("lat_busy", busy, 1);
        check("lat_prewrite", int'($signed(rd_vmem)), 0);
        @(negedge clk);
        check("lat_upd_valid", upd_valid, 1);
        check("lat_upd_idx", int'(upd_idx), 2);
        check("lat_upd_vmem", int'($signed(upd_vmem)), 100);
        check("lat_rd_new", int'($signed(rd_vmem)), 100);
        @(negedge clk);
        check("lat_upd_pulse", upd_valid, 0);
        @(posedge clk); #1;
        read_expect(3, 0, "lat_other_zero");

        // Throughput: four back-to-back events take four cycles.
        snap = upd_count;
        c0   = cyc;
        send(0, 1);
        send(1, 2);
        send(2, 3);
        send(3, 4);
        check("tput_cycles", cyc - c0, 4);
        wait_idle();
        check("tput_pulses", upd_count - snap, 4);
        read_expect(2, 103, "tput_acc");

        // Saturation at both rails.
        send(5, 32760);
        wait_idle();
        read_expect(5, 32760, "sat_pre");
        send(5, 20);
        wait_idle();
        read_expect(5, 32767, "sat_pos");
        send(5, -32768);
        wait_idle();
        read_expect(5, -1, "sat_back");
        send(6, -32768);
        send(6, -5);
        wait_idle();
        read_expect(6, -32768, "sat_neg");
        send(6, 32767);
        wait_idle();
        read_expect(6, -1, "sat_neg_back");

`ifdef DENDRITE_SCHED_LEAK_EN
        // Single sweep: eight leak writes, -1 leaks to 0.
        do_reset();
        send(0, 80);
        send(1, -80);
        send(2, -1);
        wait_idle();
        snap = upd_count;
        pulse_tick(1'b1);
        wait_idle();
        check("sweep_pulses", upd_count - snap, 8);
        read_expect(0, 70, "leak_pos");
        read_expect(1, -70, "leak_neg");
        read_expect(2, 0, "leak_minus_one");
        read_expect(3, 0, "leak_zero");
        check("sweep_no_overrun", tick_overrun, 0);

        // Events during a sweep fill the FIFO and drain afterwards in order.
        pulse_tick(1'b1);
        send(3, 10);
        send(4, 20);
        send(5, 30);
        send(6, 40);
        check("burst_ready_low", ev_ready, 0);
        check("burst_busy", busy, 1);
        send(7, 50);
        wait_idle();
        read_expect(0, 62, "burst_leak0");
        read_expect(1, -61, "burst_leak1");
        read_expect(7, 50, "burst_fifth");

        // Three ticks: second captured during the sweep, third overruns.
        do_reset();
        check("ovr_cleared", tick_overrun, 0);
        send(3, 800);
        wait_idle();
        snap = upd_count;
        pulse_tick(1'b1);
        @(posedge clk); #1;
        pulse_tick(1'b1);
        pulse_tick(1'b0);
        wait_idle();
        check("ovr_pulses", upd_count - snap, 16);
        check("ovr_flag", tick_overrun, 1);
        read_expect(3, 613, "ovr_two_leaks");

        // Reset mid-sweep with events queued.
        do_reset();
        send(4, 50);
        wait_idle();
        pulse_tick(1'b1);
        send(1, 5);
        send(2, 6);
        send(3, 7);
        check("mid_busy_pre", busy, 1);
        do_reset();
        snap = upd_count;
        check("mid_busy", busy, 0);
        check("mid_ready", ev_ready, 1);
        check("mid_upd", upd_valid, 0);
        check("mid_overrun", tick_overrun, 0);
        for (int i = 0; i < NUM_DEND; i++) read_expect(i, 0, "mid_vmem_zero");
        repeat (20) @(posedge clk);
        #1;
        check("mid_no_pulses", upd_count - snap, 0);
`else
        // Without the leak feature a tick changes nothing.
        snap = upd_count;
        pulse_tick(1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("tick_ignored", upd_count - snap, 0);
        check("tick_no_overrun", tick_overrun, 0);
        check("tick_not_busy", busy, 0);
`endif

        // Reset with an event still in the FIFO discards it.
        send(7, 9);
        do_reset();
        snap = upd_count;
        check("flush_busy", busy, 0);
        check("flush_ready", ev_ready, 1);
        check("flush_upd", upd_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("flush_no_pulses", upd_count - snap, 0);
        read_expect(7, 0, "flush_vmem");

        // Closing scan of the whole file against the model.
        send(4, -300);
        wait_idle();
        for (int i = 0; i < NUM_DEND; i++) read_expect(i, model_vmem[i], "final_model");
        read_expect(4, -300, "final_literal");
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
